// File: rtl/fetch_pkg.sv
// Shared types and constants for the branch-aware instruction fetch sequencer.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic        taken;
    logic        misaligned;
    logic [31:0] target;
  } redirect_t;

endpackage

// File: rtl/fetch_redirect_calc.sv
// Decodes a branch resolution into taken / target / misaligned for the fetch sequencer.
module fetch_redirect_calc
  import fetch_pkg::*;
(
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  input  logic [31:0] pcbr,
  output redirect_t   redirect
);

  // A zero offset is the branch unit's encoding for "not taken"; the sum wraps modulo 2^32.
  always_comb begin
    redirect.target     = br_pc + pcbr;
    redirect.taken      = br_valid && (pcbr != 32'h0);
    redirect.misaligned = redirect.taken && (redirect.target[1:0] != 2'b00);
  end

endmodule

// File: rtl/branch_fetch_sequencer.sv
// Program-counter owner: one-outstanding instruction fetch over req/gnt/rvalid,
// valid/ready hand-off to decode, and squash/redirect on taken branches.
module branch_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  output logic            oIMEM_REQ,
  output logic [XLEN-1:0] oIMEM_ADDR,
  input  logic            iIMEM_GNT,
  input  logic            iIMEM_RVALID,
  input  logic [XLEN-1:0] iIMEM_RDATA,
  output logic [XLEN-1:0] oIR,
  output logic [XLEN-1:0] oPC,
  output logic            oIR_VALID,
  input  logic            iIR_READY,
  input  logic            iBR_VALID,
  input  logic [XLEN-1:0] iBR_PC,
  input  logic [XLEN-1:0] iPCBR,
  output logic            oMISALIGN
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] ir_pc_q, ir_pc_d;
  logic            ir_valid_q, ir_valid_d;
  logic            drop_q, drop_d;
  logic            misalign_q, misalign_d;
  logic            run_q;
  logic            gnt_ok;
  redirect_t       redirect;

  fetch_redirect_calc u_redirect (
    .br_valid (iBR_VALID),
    .br_pc    (iBR_PC),
    .pcbr     (iPCBR),
    .redirect (redirect)
  );

  // run_q keeps the request low for the first cycle out of reset.
  assign oIMEM_REQ  = run_q && (state_q == S_REQ);
  assign oIMEM_ADDR = pc_q;
  assign oIR        = ir_q;
  assign oPC        = ir_pc_q;
  assign oIR_VALID  = ir_valid_q;
  assign oMISALIGN  = misalign_q;
  assign gnt_ok     = oIMEM_REQ && iIMEM_GNT;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    drop_d     = drop_q;
    misalign_d = misalign_q;

    if ((state_q != S_HALT) && redirect.taken) begin
      if (redirect.misaligned) begin
        misalign_d = 1'b1;
        ir_valid_d = 1'b0;
        drop_d     = 1'b0;
        state_d    = S_HALT;
      end else begin
        pc_d = redirect.target;
        case (state_q)
          S_REQ: begin
            if (gnt_ok) begin
              drop_d  = 1'b1;
              state_d = S_WAIT;
            end
          end
          S_WAIT: begin
            if (iIMEM_RVALID) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              drop_d = 1'b1;
            end
          end
          S_HOLD: begin
            // The held instruction is wrong-path even if decode is accepting it right now.
            ir_valid_d = 1'b0;
            state_d    = S_REQ;
          end
          default: ;
        endcase
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (gnt_ok) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (iIMEM_RVALID) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              ir_d       = iIMEM_RDATA;
              ir_pc_d    = pc_q;
              ir_valid_d = 1'b1;
              pc_d       = pc_q + PC_INC;
              state_d    = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (iIR_READY) begin
            ir_valid_d = 1'b0;
            state_d    = S_REQ;
          end
        end
        S_HALT: begin
          ir_valid_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= RESET_PC;
      ir_valid_q <= 1'b0;
      drop_q     <= 1'b0;
      misalign_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
      run_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_fetch_sequencer.sv
// Randomised bench for branch_fetch_sequencer: bench-side memory plus a next-expected-PC program model.
module tb_branch_fetch_sequencer;

  localparam logic [31:0] ALT_RESET_PC = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, gnt, rvalid, ready, br_valid;
  logic [31:0] rdata, br_pc, pcbr;

  logic        req0, ir_valid0, misalign0, req1, ir_valid1, misalign1;
  logic [31:0] addr0, ir0, pc0, addr1, ir1, pc1;

  branch_fetch_sequencer #(.RESET_PC(32'h0000_0000)) u_dut0 (
    .iCLK(clk), .iRST_N(rst_n), .oIMEM_REQ(req0), .oIMEM_ADDR(addr0), .iIMEM_GNT(gnt),
    .iIMEM_RVALID(rvalid), .iIMEM_RDATA(rdata), .oIR(ir0), .oPC(pc0), .oIR_VALID(ir_valid0),
    .iIR_READY(ready), .iBR_VALID(br_valid), .iBR_PC(br_pc), .iPCBR(pcbr), .oMISALIGN(misalign0)
  );

  branch_fetch_sequencer #(.RESET_PC(ALT_RESET_PC)) u_dut1 (
    .iCLK(clk), .iRST_N(rst_n), .oIMEM_REQ(req1), .oIMEM_ADDR(addr1), .iIMEM_GNT(gnt),
    .iIMEM_RVALID(rvalid), .iIMEM_RDATA(rdata), .oIR(ir1), .oPC(pc1), .oIR_VALID(ir_valid1),
    .iIR_READY(ready), .iBR_VALID(br_valid), .iBR_PC(br_pc), .iPCBR(pcbr), .oMISALIGN(misalign1)
  );

  bit          sel;
  logic        obs_req, obs_valid, obs_misalign;
  logic [31:0] obs_addr, obs_ir, obs_pc;
  assign obs_req      = sel ? req1 : req0;
  assign obs_valid    = sel ? ir_valid1 : ir_valid0;
  assign obs_misalign = sel ? misalign1 : misalign0;
  assign obs_addr     = sel ? addr1 : addr0;
  assign obs_ir       = sel ? ir1 : ir0;
  assign obs_pc       = sel ? pc1 : pc0;

  int n_checks = 0;
  int n_fail   = 0;

  // Program model and memory state.
  logic [31:0] exp_pc, pend_addr, last_grant_addr;
  bit          halted, pend;
  int          pend_cnt, grants, deliveries, cyc;
  int          gnt_pct = 100, lat_min = 1, lat_max = 1;
  logic [31:0] dlog[$];
  int          dcyc[$];

  bit          prev_ok, prev_req, prev_gnt, prev_valid, prev_ready, prev_taken;
  logic [31:0] prev_addr, prev_ir, prev_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b0;
    br_valid = 1'b0; br_pc = '0; pcbr = '0;
    pend = 0; pend_cnt = 0; halted = 0; prev_ok = 0; grants = 0; deliveries = 0; cyc = 0;
    dlog.delete(); dcyc.delete();
    exp_pc = sel ? ALT_RESET_PC : 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of bench activity: observe at negedge, check, update model, drive next inputs.
  task automatic cycle(input bit rdy, input bit bv, input logic [31:0] bpc, input logic [31:0] off);
    bit          taken, gnt_v, rvalid_v;
    logic [31:0] tgt, resp_addr;
    @(negedge clk);
    cyc++;
    if (halted) begin
      n_checks++;
      if ({obs_misalign, obs_req, obs_valid} !== 3'b100) begin
        n_fail++;
        $display("FAIL halt_outputs: misalign/req/valid got %b expected 100", {obs_misalign, obs_req, obs_valid});
      end
    end else if (prev_ok) begin
      if (prev_req && !prev_gnt && !prev_taken) begin
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL addr_hold: req=%b addr=%h expected req=1 addr=%h", obs_req, obs_addr, prev_addr);
        end
      end
      if (prev_valid && !prev_ready && !prev_taken) begin
        n_checks++;
        if (obs_valid !== 1'b1 || obs_ir !== prev_ir || obs_pc !== prev_pc) begin
          n_fail++;
          $display("FAIL hold_stable: valid=%b ir=%h pc=%h expected valid=1 ir=%h pc=%h",
                   obs_valid, obs_ir, obs_pc, prev_ir, prev_pc);
        end
      end
      if (obs_req) begin
        n_checks++;
        if (pend || obs_valid) begin
          n_fail++;
          $display("FAIL one_outstanding: req=1 with pending=%b valid=%b expected both 0", pend, obs_valid);
        end
      end
    end

    rvalid_v  = 1'b0;
    resp_addr = pend_addr;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        rvalid_v = 1'b1;
        pend     = 0;
      end
    end
    gnt_v = obs_req && ($urandom_range(0, 99) < gnt_pct);
    taken = bv && (off != 32'h0);
    tgt   = bpc + off;

    if (!halted) begin
      if (taken) begin
        if (tgt[1:0] != 2'b00) halted = 1;
        else exp_pc = tgt;
      end else begin
        if (gnt_v) begin
          n_checks++;
          if (obs_addr !== exp_pc) begin
            n_fail++;
            $display("FAIL grant_addr: got %h expected %h", obs_addr, exp_pc);
          end
        end
        if (obs_valid && rdy) begin
          n_checks++;
          if (obs_pc !== exp_pc || obs_ir !== mem_word(exp_pc)) begin
            n_fail++;
            $display("FAIL deliver: pc=%h ir=%h expected pc=%h ir=%h", obs_pc, obs_ir, exp_pc, mem_word(exp_pc));
          end
          dlog.push_back(obs_pc);
          dcyc.push_back(cyc);
          deliveries++;
          exp_pc = exp_pc + 32'd4;
        end
      end
    end

    if (gnt_v) begin
      pend            = 1;
      pend_cnt        = $urandom_range(lat_min, lat_max);
      pend_addr       = obs_addr;
      last_grant_addr = obs_addr;
      grants++;
    end

    gnt      = gnt_v;
    rvalid   = rvalid_v;
    rdata    = rvalid_v ? mem_word(resp_addr) : $urandom();
    ready    = rdy;
    br_valid = bv;
    br_pc    = bpc;
    pcbr     = off;

    prev_ok    = 1;
    prev_req   = obs_req;
    prev_gnt   = gnt_v;
    prev_addr  = obs_addr;
    prev_valid = obs_valid;
    prev_ready = rdy;
    prev_taken = taken;
    prev_ir    = obs_ir;
    prev_pc    = obs_pc;
  endtask

  task automatic wait_grants(input int n);
    int budget = 60;
    while (grants < n && budget > 0) begin
      cycle(1'b1, 1'b0, 32'h0, 32'h0);
      budget--;
    end
    n_checks++;
    if (grants < n) begin
      n_fail++;
      $display("FAIL grant_timeout: grants=%0d expected %0d", grants, n);
    end
  endtask

  task automatic wait_deliveries(input int n);
    int budget = 100;
    while (deliveries < n && budget > 0) begin
      cycle(1'b1, 1'b0, 32'h0, 32'h0);
      budget--;
    end
    n_checks++;
    if (deliveries < n) begin
      n_fail++;
      $display("FAIL deliver_timeout: deliveries=%0d expected %0d", deliveries, n);
    end
  endtask

  task automatic wait_valid_stalled();
    int budget = 40;
    bit seen = 0;
    while (!seen && budget > 0) begin
      cycle(1'b0, 1'b0, 32'h0, 32'h0);
      seen = prev_valid;
      budget--;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL valid_timeout: oIR_VALID got 0 expected 1");
    end
  endtask

  task automatic test_reset();
    sel = 0;
    rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b0;
    br_valid = 1'b0; br_pc = '0; pcbr = '0;
    #12;
    n_checks++;
    if ({req0, ir_valid0, misalign0} !== 3'b000 || ir0 !== 32'h0 || pc0 !== 32'h0 || pc1 !== ALT_RESET_PC) begin
      n_fail++;
      $display("FAIL reset_outputs: req/valid/mis=%b ir=%h pc=%h pc_alt=%h expected 000 0 0 %h",
               {req0, ir_valid0, misalign0}, ir0, pc0, pc1, ALT_RESET_PC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req0 !== 1'b0) begin
      n_fail++;
      $display("FAIL req_after_release: got %b expected 0", req0);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (req0 !== 1'b1 || addr0 !== 32'h0) begin
      n_fail++;
      $display("FAIL first_req: req=%b addr=%h expected 1 00000000", req0, addr0);
    end
  endtask

  task automatic test_sequential();
    sel = 0; gnt_pct = 100; lat_min = 1; lat_max = 1;
    reset_dut();
    wait_deliveries(3);
    if (deliveries >= 3) begin
      n_checks++;
      if (dlog[0] !== 32'h0 || dlog[1] !== 32'h4 || dlog[2] !== 32'h8) begin
        n_fail++;
        $display("FAIL seq_order: got %h %h %h expected 0 4 8", dlog[0], dlog[1], dlog[2]);
      end
      n_checks++;
      if (dcyc[2] - dcyc[1] != 3) begin
        n_fail++;
        $display("FAIL seq_rate: got %0d cycles/instr expected 3", dcyc[2] - dcyc[1]);
      end
    end
  endtask

  task automatic test_stall();
    int g0;
    sel = 0; gnt_pct = 100; lat_min = 1; lat_max = 1;
    reset_dut();
    wait_valid_stalled();
    g0 = grants;
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++;
    if (grants != g0 || prev_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_no_req: grants=%0d valid=%b expected %0d 1", grants, prev_valid, g0);
    end
    wait_grants(g0 + 1);
    n_checks++;
    if (last_grant_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL stall_next_addr: got %h expected 00000004", last_grant_addr);
    end
  endtask

  task automatic test_branch_wait();
    sel = 0; gnt_pct = 100; lat_min = 3; lat_max = 3;
    reset_dut();
    wait_grants(1);
    cycle(1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFF8);
    wait_grants(2);
    n_checks++;
    if (last_grant_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL wait_redirect_addr: got %h expected 00000008", last_grant_addr);
    end
    wait_deliveries(1);
    if (deliveries >= 1) begin
      n_checks++;
      if (dlog[0] !== 32'h8) begin
        n_fail++;
        $display("FAIL wait_redirect_deliver: got %h expected 00000008", dlog[0]);
      end
    end
  endtask

  task automatic test_not_taken_and_hold();
    int budget = 60;
    int d0, g0;
    sel = 0; gnt_pct = 100; lat_min = 1; lat_max = 2;
    reset_dut();
    while (deliveries < 3 && budget > 0) begin
      cycle(1'b1, 1'b1, $urandom() & 32'hFFFF_FFFC, 32'h0);
      budget--;
    end
    n_checks++;
    if (deliveries < 3 || dlog[0] !== 32'h0 || dlog[1] !== 32'h4 || dlog[2] !== 32'h8) begin
      n_fail++;
      $display("FAIL not_taken_seq: deliveries=%0d expected 3 in order 0 4 8", deliveries);
    end
    wait_valid_stalled();
    d0 = deliveries;
    g0 = grants;
    cycle(1'b1, 1'b1, 32'h0000_0080, 32'h0000_0040);
    @(posedge clk);
    #1;
    n_checks++;
    if (obs_valid !== 1'b0 || deliveries != d0) begin
      n_fail++;
      $display("FAIL hold_squash: valid=%b deliveries=%0d expected 0 %0d", obs_valid, deliveries, d0);
    end
    wait_grants(g0 + 1);
    n_checks++;
    if (last_grant_addr !== 32'hC0) begin
      n_fail++;
      $display("FAIL hold_redirect_addr: got %h expected 000000c0", last_grant_addr);
    end
  endtask

  task automatic test_misalign_and_reset();
    sel = 0; gnt_pct = 100; lat_min = 1; lat_max = 2;
    reset_dut();
    repeat (4) cycle(1'b1, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0006);
    @(posedge clk);
    #1;
    n_checks++;
    if (obs_misalign !== 1'b1 || obs_req !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_flag: misalign=%b req=%b expected 1 0", obs_misalign, obs_req);
    end
    repeat (4) cycle(1'b1, 1'b0, 32'h0, 32'h0);
    repeat (4) cycle(1'b1, 1'b1, 32'h0, 32'h0000_0040);
    reset_dut();
    wait_grants(1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({obs_req, obs_valid, obs_misalign} !== 3'b000 || obs_ir !== 32'h0 || obs_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: req/valid/mis=%b ir=%h pc=%h expected 000 0 0",
               {obs_req, obs_valid, obs_misalign}, obs_ir, obs_pc);
    end
  endtask

  task automatic test_pc_wrap();
    sel = 1; gnt_pct = 100; lat_min = 1; lat_max = 1;
    reset_dut();
    wait_deliveries(2);
    if (deliveries >= 2) begin
      n_checks++;
      if (dlog[0] !== ALT_RESET_PC || dlog[1] !== 32'h0) begin
        n_fail++;
        $display("FAIL pc_wrap: got %h %h expected fffffffc 00000000", dlog[0], dlog[1]);
      end
    end
    sel = 0;
  endtask

  task automatic test_random();
    logic [31:0] off;
    bit bv;
    sel = 0; gnt_pct = 60; lat_min = 1; lat_max = 4;
    reset_dut();
    for (int i = 0; i < 1500; i++) begin
      bv  = ($urandom_range(0, 99) < 12);
      off = $urandom_range(0, 5) == 0 ? 32'h0 : ($urandom_range(1, 256) << 2);
      if ($urandom_range(0, 1) == 1) off = -off;
      cycle($urandom_range(0, 99) < 70, bv, $urandom() & 32'hFFFF_FFFC, off);
    end
    n_checks++;
    if (deliveries < 20) begin
      n_fail++;
      $display("FAIL random_progress: deliveries=%0d expected at least 20", deliveries);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish expected done");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_not_taken_and_hold();
    test_misalign_and_reset();
    test_pc_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
